// File: rtl/bexkat_bus_pkg.sv
// Shared bus-side types and constants for the SSRAM controller.
// Also used by the optional SSRAM_READ_CACHE_EN read buffer.
package bexkat_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DONE
    } ssram_state_t;

    localparam logic [3:0] CS_SSRAM     = 4'h6;
    localparam int         SSRAM_ADDR_W = 20;

endpackage

// File: rtl/ssram_rdbuf.sv
// Single-entry read buffer (valid/tag/data) in front of the SSRAM.
// Instantiated by ssram_ctrl only when SSRAM_READ_CACHE_EN is defined.
module ssram_rdbuf #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] lookup_tag,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] fill_tag,
    input  logic [31:0]           fill_data,
    input  logic                  inval,
    input  logic [ADDR_WIDTH-1:0] inval_tag,
    output logic                  hit,
    output logic [31:0]           hit_data
);

    logic                  valid;
    logic [ADDR_WIDTH-1:0] tag;
    logic [31:0]           data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end else if (inval && (inval_tag == tag)) begin
            valid <= 1'b0;
        end
    end

    assign hit      = valid && (tag == lookup_tag);
    assign hit_data = data;

endmodule

// File: rtl/ssram_ctrl.sv
// Bus-side controller for a pipelined, ADSC-started, byte-writable 1M x 32 SSRAM.
// Optional macro SSRAM_READ_CACHE_EN adds a one-entry read buffer (ssram_rdbuf).
module ssram_ctrl
    import bexkat_bus_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int ADDR_WIDTH   = SSRAM_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  select,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [3:0]            be,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_adsc_n,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n,
    output logic [31:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [31:0]           sram_dq_in
);

    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    ssram_state_t          state, state_next;
    logic [2:0]            cnt, cnt_next;
    logic                  is_read, is_read_next;
    logic                  abort, abort_next;
    logic [31:0]           data_out_next;
    logic                  ready_next;
    logic [ADDR_WIDTH-1:0] sram_addr_next;
    logic                  adsc_next, ce_next, oe_next, we_next, dq_oe_next;
    logic [3:0]            be_n_next;
    logic [31:0]           dq_out_next;

    logic                  active;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  hit, fill, inval;
    logic [31:0]           hit_data;

    assign active    = read || write;
    assign word_addr = address[ADDR_WIDTH+1:2];

    logic unused_addr;
    assign unused_addr = ^{address[31:ADDR_WIDTH+2], address[1:0]};

`ifdef SSRAM_READ_CACHE_EN
    ssram_rdbuf #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rdbuf (
        .clock      (clock),
        .reset_n    (reset_n),
        .lookup_tag (word_addr),
        .fill       (fill),
        .fill_tag   (sram_addr),
        .fill_data  (sram_dq_in),
        .inval      (inval),
        .inval_tag  (word_addr),
        .hit        (hit),
        .hit_data   (hit_data)
    );
`else
    logic unused_buf;
    assign hit        = 1'b0;
    assign hit_data   = '0;
    assign unused_buf = fill ^ inval;
`endif

    // Pin values are computed for the state being entered, then registered,
    // so nothing combinational reaches the pads.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        is_read_next   = is_read;
        abort_next     = abort;
        data_out_next  = data_out;
        ready_next     = 1'b0;
        sram_addr_next = sram_addr;
        adsc_next      = 1'b1;
        ce_next        = 1'b1;
        oe_next        = 1'b1;
        we_next        = 1'b1;
        be_n_next      = 4'hf;
        dq_out_next    = sram_dq_out;
        dq_oe_next     = 1'b0;
        fill           = 1'b0;
        inval          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && select && active) begin
                    is_read_next   = read;
                    abort_next     = 1'b0;
                    sram_addr_next = word_addr;
                    if (read && hit) begin
                        state_next    = ST_DONE;
                        data_out_next = hit_data;
                        ready_next    = 1'b1;
                    end else begin
                        state_next = ST_ADDR;
                        adsc_next  = 1'b0;
                        ce_next    = 1'b0;
                        if (read) begin
                            oe_next  = 1'b0;
                            cnt_next = CNT_LOAD;
                        end else begin
                            we_next     = 1'b0;
                            be_n_next   = ~be;
                            dq_oe_next  = 1'b1;
                            dq_out_next = data_in;
                            inval       = 1'b1;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (is_read) begin
                    state_next = ST_WAIT;
                    oe_next    = 1'b0;
                    abort_next = abort || !active;
                end else if (active) begin
                    state_next = ST_DONE;
                    ready_next = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    // An aborted read still runs out the SSRAM pipeline but is not returned.
                    if (!abort && active) begin
                        state_next    = ST_DONE;
                        ready_next    = 1'b1;
                        data_out_next = sram_dq_in;
                        fill          = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next   = cnt - 3'd1;
                    oe_next    = 1'b0;
                    abort_next = abort || !active;
                end
            end
            ST_DONE: begin
                if (active) ready_next = 1'b1;
                else        state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            is_read     <= 1'b0;
            abort       <= 1'b0;
            data_out    <= '0;
            ready       <= 1'b0;
            sram_addr   <= '0;
            sram_adsc_n <= 1'b1;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_be_n   <= 4'hf;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            is_read     <= is_read_next;
            abort       <= abort_next;
            data_out    <= data_out_next;
            ready       <= ready_next;
            sram_addr   <= sram_addr_next;
            sram_adsc_n <= adsc_next;
            sram_ce_n   <= ce_next;
            sram_oe_n   <= oe_next;
            sram_we_n   <= we_next;
            sram_be_n   <= be_n_next;
            sram_dq_out <= dq_out_next;
            sram_dq_oe  <= dq_oe_next;
        end
    end

endmodule

// File: tb/tb_ssram_ctrl.sv
// Directed bench for ssram_ctrl with a latency-2 pipelined SSRAM model.
// Cache expectations switch on SSRAM_READ_CACHE_EN.
module tb_ssram_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, select, read, write;
    logic [31:0] address, data_in, data_out;
    logic [3:0]  be;
    logic        ready;
    logic [19:0] sram_addr;
    logic        sram_adsc_n, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [3:0]  sram_be_n;
    logic [31:0] sram_dq_out, sram_dq_in;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ssram_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .select      (select),
        .read        (read),
        .write       (write),
        .address     (address),
        .be          (be),
        .data_in     (data_in),
        .data_out    (data_out),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_adsc_n (sram_adsc_n),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_be_n   (sram_be_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    // SSRAM model: address/write sampled on ADSC, read data on DQ two clocks later.
    logic [31:0] mem [logic [19:0]];
    logic [31:0] rd_pipe = 32'h0;
    logic [31:0] mw;
    initial sram_dq_in = 32'h0;
    always @(posedge clock) begin
        if (!sram_adsc_n && !sram_ce_n) begin
            mw = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
            if (!sram_we_n) begin
                for (int i = 0; i < 4; i++)
                    if (!sram_be_n[i]) mw[8*i +: 8] = sram_dq_out[8*i +: 8];
                mem[sram_addr] = mw;
                rd_pipe <= 32'h0;
            end else begin
                rd_pipe <= mw;
            end
        end else begin
            rd_pipe <= 32'h0;
        end
        sram_dq_in <= rd_pipe;
    end

    typedef struct {
        int          lat;
        int          oe_cnt;
        int          we_cnt;
        int          adsc_cnt;
        logic [3:0]  be_seen;
        logic [19:0] addr_seen;
        logic [31:0] dq_seen;
        logic [31:0] dout;
        logic        rdy_after;
    } obs_t;

    typedef struct {
        logic        rd;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        int          lat;
        logic [19:0] sa;
        logic [31:0] dout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Starts at 1 time unit after a rising edge and ends the same way.
    task automatic do_cycle(input logic rd, input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d, output obs_t o);
        o = '{lat: -1, be_seen: 4'hf, default: 0};
        start = 1'b1; select = 1'b1; read = rd; write = !rd;
        address = a; be = b; data_in = d;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (!sram_adsc_n) begin o.adsc_cnt++; o.addr_seen = sram_addr; end
            if (!sram_oe_n) o.oe_cnt++;
            if (!sram_we_n) begin
                o.we_cnt++;
                o.be_seen = sram_be_n;
                o.dq_seen = sram_dq_oe ? sram_dq_out : 32'h0;
            end
            if (ready) begin o.lat = n; o.dout = data_out; break; end
            tick();
        end
        if (o.lat > 0) tick();
        read = 1'b0; write = 1'b0;
        tick();
        o.rdy_after = ready;
    endtask

    task automatic chk_idle_pins(input string nm);
        chk({nm, "_strobes"}, {28'h0, sram_adsc_n, sram_ce_n, sram_oe_n, sram_we_n}, 32'hf);
        chk({nm, "_dq_oe"}, {31'h0, sram_dq_oe}, 32'h0);
        chk({nm, "_ready"}, {31'h0, ready}, 32'h0);
    endtask

    vec_t vt [9];
    obs_t o;
    int   viol;
`ifdef SSRAM_READ_CACHE_EN
    localparam int HIT_LAT  = 1;
    localparam int HIT_ADSC = 0;
`else
    localparam int HIT_LAT  = 4;
    localparam int HIT_ADSC = 1;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 32'h00004010, 4'hf,    32'hDEADBEEF, 2, 20'h01004, 32'h00000000};
        vt[1] = '{1'b1, 32'h00004010, 4'hf,    32'h0,        4, 20'h01004, 32'hDEADBEEF};
        vt[2] = '{1'b0, 32'h00004010, 4'b0010, 32'h0000AA00, 2, 20'h01004, 32'hDEADBEEF};
        vt[3] = '{1'b1, 32'h00004010, 4'hf,    32'h0,        4, 20'h01004, 32'hDEADAAEF};
        vt[4] = '{1'b0, 32'hFFC04013, 4'b1000, 32'h11000000, 2, 20'h01004, 32'hDEADAAEF};
        vt[5] = '{1'b1, 32'h00004010, 4'hf,    32'h0,        4, 20'h01004, 32'h11ADAAEF};
        vt[6] = '{1'b0, 32'h003FFFFC, 4'hf,    32'hCAFEF00D, 2, 20'hFFFFF, 32'h11ADAAEF};
        vt[7] = '{1'b1, 32'h003FFFFC, 4'hf,    32'h0,        4, 20'hFFFFF, 32'hCAFEF00D};
        vt[8] = '{1'b1, 32'h00000000, 4'hf,    32'h0,        4, 20'h00000, 32'h00000000};

        reset_n = 1'b0; start = 1'b0; select = 1'b0; read = 1'b0; write = 1'b0;
        address = 32'h0; be = 4'h0; data_in = 32'h0;
        #12;
        chk_idle_pins("reset");
        chk("reset_data_out", data_out, 32'h0);
        chk("reset_sram_addr", {12'h0, sram_addr}, 32'h0);
        chk("reset_be_n", {28'h0, sram_be_n}, 32'hf);
        chk("reset_dq_out", sram_dq_out, 32'h0);
        @(negedge clock) reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            do_cycle(vt[i].rd, vt[i].a, vt[i].b, vt[i].d, o);
            chk($sformatf("v%0d_latency", i), o.lat, vt[i].lat);
            chk($sformatf("v%0d_data_out", i), o.dout, vt[i].dout);
            chk($sformatf("v%0d_sram_addr", i), {12'h0, o.addr_seen}, {12'h0, vt[i].sa});
            chk($sformatf("v%0d_adsc_cnt", i), o.adsc_cnt, 1);
            chk($sformatf("v%0d_be_n", i), {28'h0, o.be_seen}, {28'h0, vt[i].rd ? 4'hf : ~vt[i].b});
            chk($sformatf("v%0d_we_cnt", i), o.we_cnt, vt[i].rd ? 0 : 1);
            chk($sformatf("v%0d_oe_cnt", i), o.oe_cnt, vt[i].rd ? 3 : 0);
            chk($sformatf("v%0d_dq_out", i), o.dq_seen, vt[i].rd ? 32'h0 : vt[i].d);
            chk($sformatf("v%0d_ready_drop", i), {31'h0, o.rdy_after}, 32'h0);
        end

        // start without select: no pin activity, no ready
        viol = 0;
        start = 1'b1; select = 1'b0; read = 1'b1; address = 32'h00800800;
        tick();
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (!sram_adsc_n || !sram_ce_n || !sram_oe_n || !sram_we_n || sram_dq_oe || ready)
                viol++;
            tick();
        end
        read = 1'b0;
        chk("nosel_activity", viol, 0);

        // reset asserted while the read is in WAIT
        start = 1'b1; select = 1'b1; read = 1'b1; address = 32'h00004010;
        tick();
        start = 1'b0;
        tick();
        chk("wait_oe_low", {31'h0, sram_oe_n}, 32'h0);
        reset_n = 1'b0;
        #1;
        chk_idle_pins("rst_wait");
        @(negedge clock) reset_n = 1'b1;
        read = 1'b0;
        tick();

        // reset asserted while a write drives DQ
        start = 1'b1; select = 1'b1; write = 1'b1; address = 32'h00004010;
        be = 4'hf; data_in = 32'h12345678;
        tick();
        start = 1'b0;
        chk("addr_dq_oe_high", {31'h0, sram_dq_oe}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk_idle_pins("rst_addr");
        chk("rst_addr_data_out", data_out, 32'h0);
        @(negedge clock) reset_n = 1'b1;
        write = 1'b0;
        tick();

        do_cycle(1'b1, 32'h003FFFFC, 4'hf, 32'h0, o);
        chk("post_rst_latency", o.lat, 4);
        chk("post_rst_data_out", o.dout, 32'hCAFEF00D);

        // read aborted during WAIT: access runs out, no ready, data_out kept
        start = 1'b1; select = 1'b1; read = 1'b1; address = 32'h00004010;
        tick();
        start = 1'b0;
        tick();
        read = 1'b0;
        viol = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (ready) viol++;
            tick();
        end
        chk("abort_ready", viol, 0);
        chk("abort_data_out", data_out, 32'hCAFEF00D);
        chk("abort_oe_released", {31'h0, sram_oe_n}, 32'h1);

        // back-to-back reads of one word, then a write invalidates it
        do_cycle(1'b1, 32'h00004010, 4'hf, 32'h0, o);
        chk("rd1_latency", o.lat, 4);
        chk("rd1_data_out", o.dout, 32'h11ADAAEF);
        do_cycle(1'b1, 32'h00004010, 4'hf, 32'h0, o);
        chk("rd2_latency", o.lat, HIT_LAT);
        chk("rd2_adsc_cnt", o.adsc_cnt, HIT_ADSC);
        chk("rd2_data_out", o.dout, 32'h11ADAAEF);
        do_cycle(1'b0, 32'h00004010, 4'b0001, 32'h00000055, o);
        chk("wr_inval_latency", o.lat, 2);
        do_cycle(1'b1, 32'h00004010, 4'hf, 32'h0, o);
        chk("rd3_latency", o.lat, 4);
        chk("rd3_adsc_cnt", o.adsc_cnt, 1);
        chk("rd3_data_out", o.dout, 32'h11ADAA55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
